fp_addsub_seq: RTL and testbench

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

---
 rtl/fp_addsub_seq_if.sv | 15 +
 rtl/fp_addsub_seq.sv | 104 ++++++++++
 tb/tb_fp_addsub_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_seq_if.sv
// fp_addsub_seq_if: operand and result handshake bundle for the sequential FP adder/subtractor.
interface fp_addsub_seq_if #(parameter int EXP_WIDTH = 8, parameter int MAN_WIDTH = 23);
    logic                 in_valid, in_ready, op_sub, a_sign, b_sign;
    logic [EXP_WIDTH-1:0] a_exp, b_exp, res_exp;
    logic [MAN_WIDTH-1:0] a_man, b_man, res_man;
    logic                 out_valid, out_ready, res_sign, overflow, inexact, busy;
    modport master (
        output in_valid, op_sub, a_sign, b_sign, a_exp, b_exp, a_man, b_man, out_ready,
        input  in_ready, out_valid, res_sign, res_exp, res_man, overflow, inexact, busy
    );
    modport slave (
        input  in_valid, op_sub, a_sign, b_sign, a_exp, b_exp, a_man, b_man, out_ready,
        output in_ready, out_valid, res_sign, res_exp, res_man, overflow, inexact, busy
    );
endinterface

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle truncating floating-point adder/subtractor (align, add, normalize).
module fp_addsub_seq #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input logic            clk,
    input logic            rst_n,
    fp_addsub_seq_if.slave bus
);
    localparam int W = MAN_WIDTH + 3;
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
    state_t               state, state_n;
    logic                 sign_l, sign_s, sticky, eff_b, a_is_l, carry, ovf, flush;
    logic [EXP_WIDTH-1:0] exp_r, d, exp_inc;
    logic [W-1:0]         man_l, man_s, man_a, man_b;
    logic [W:0]           sum;

    assign eff_b   = bus.b_sign ^ bus.op_sub;
    assign a_is_l  = {bus.a_exp, bus.a_man} >= {bus.b_exp, bus.b_man};
    assign man_a   = {bus.a_exp != '0, bus.a_man, 2'b00};
    assign man_b   = {bus.b_exp != '0, bus.b_man, 2'b00};
    assign flush   = 32'(d) > 32'(MAN_WIDTH + 2);
    // L is never smaller than aligned S, so the difference cannot go negative
    assign sum     = (sign_l == sign_s) ? {1'b0, man_l} + {1'b0, man_s} : {1'b0, man_l} - {1'b0, man_s};
    assign carry   = sum[W];
    assign exp_inc = exp_r + EXP_WIDTH'(1);
    assign ovf     = carry && (&exp_inc);

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.in_valid ? ALIGN : IDLE;
            ALIGN:   state_n = (flush || d == '0) ? ADD : ALIGN;
            ADD:     state_n = (ovf || sum == '0) ? DONE : NORM;
            NORM:    state_n = (man_l[W-1] || exp_r <= EXP_WIDTH'(1)) ? DONE : NORM;
            DONE:    state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sign_l, sign_s, sticky} <= '0;
            {exp_r, d, man_l, man_s} <= '0;
            {bus.res_sign, bus.res_exp, bus.res_man, bus.overflow, bus.inexact} <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign_l <= a_is_l ? bus.a_sign : eff_b;
                    sign_s <= a_is_l ? eff_b : bus.a_sign;
                    exp_r  <= a_is_l ? bus.a_exp : bus.b_exp;
                    d      <= a_is_l ? bus.a_exp - bus.b_exp : bus.b_exp - bus.a_exp;
                    man_l  <= a_is_l ? man_a : man_b;
                    man_s  <= a_is_l ? man_b : man_a;
                    sticky <= 1'b0;
                end
                ALIGN: if (flush) begin
                    man_s  <= '0;
                    sticky <= |man_s;
                    d      <= '0;
                end else if (d != '0) begin
                    man_s  <= man_s >> 1;
                    sticky <= sticky | man_s[0];
                    d      <= d - EXP_WIDTH'(1);
                end
                ADD: if (carry) begin
                    man_l  <= sum[W:1];
                    sticky <= sticky | sum[0];
                    exp_r  <= exp_inc;
                    if (ovf) begin
                        bus.res_sign <= sign_l;
                        bus.res_exp  <= '1;
                        bus.res_man  <= '0;
                        bus.overflow <= 1'b1;
                        bus.inexact  <= sum[2] | sum[1] | sum[0] | sticky;
                    end
                end else if (sum == '0) begin
                    {bus.res_sign, bus.res_exp, bus.res_man, bus.overflow, bus.inexact} <= '0;
                end else begin
                    man_l <= sum[W-1:0];
                end
                NORM: if (!man_l[W-1] && exp_r > EXP_WIDTH'(1)) begin
                    man_l <= man_l << 1;
                    exp_r <= exp_r - EXP_WIDTH'(1);
                end else begin
                    bus.res_sign <= sign_l;
                    bus.res_exp  <= man_l[W-1] ? exp_r : '0;
                    bus.res_man  <= man_l[W-2:2];
                    bus.overflow <= 1'b0;
                    bus.inexact  <= man_l[1] | man_l[0] | sticky;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: random and directed operands checked against an arithmetic reference model.
module tb_fp_addsub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fp_addsub_seq_if bus ();
    fp_addsub_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: integer arithmetic on {hidden, fraction, guard, round}, latency from cycle rules
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                  output logic [31:0] res, output logic ovf, output logic inx, output int lat);
        logic [31:0] l, s, bb;
        longint      ml, ms, sum;
        int          el, es, d, e, al, nrm;
        logic        st;
        bb  = {b[31] ^ sub, b[30:0]};
        l   = (a[30:0] >= b[30:0]) ? a : bb;
        s   = (a[30:0] >= b[30:0]) ? bb : a;
        el  = int'(l[30:23]);
        es  = int'(s[30:23]);
        ml  = longint'({l[30:23] != 8'd0, l[22:0], 2'b00});
        ms  = longint'({s[30:23] != 8'd0, s[22:0], 2'b00});
        d   = el - es;
        ovf = 1'b0;
        inx = 1'b0;
        if (d > 25) begin
            al = 1;
            st = ms != 0;
            ms = 0;
        end else begin
            al = d + 1;
            st = (ms & ((longint'(1) << d) - 1)) != 0;
            ms = ms >> d;
        end
        sum = (l[31] == s[31]) ? ml + ms : ml - ms;
        e = el;
        if (sum >= (longint'(1) << 26)) begin
            st  = st | ((sum & 1) != 0);
            sum = sum >> 1;
            e++;
            if (e == 255) begin
                res = {l[31], 8'hFF, 23'd0};
                ovf = 1'b1;
                inx = ((sum & 3) != 0) || st;
                lat = al + 2;
                return;
            end
        end
        if (sum == 0) begin
            res = 32'd0;
            lat = al + 2;
            return;
        end
        nrm = 1;
        while (sum < (longint'(1) << 25) && e > 1) begin
            sum = sum << 1;
            e--;
            nrm++;
        end
        if (sum < (longint'(1) << 25)) e = 0;
        res = {l[31], 8'(e), 23'(sum >> 2)};
        inx = ((sum & 3) != 0) || st;
        lat = al + 1 + nrm + 1;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input int stall,
                         input bit hold_iv, input string tag, output logic [31:0] got, output int lat);
        logic [31:0] er, r;
        logic        eo, ei;
        int          el;
        model(a, b, sub, er, eo, ei, el);
        {bus.a_sign, bus.a_exp, bus.a_man} = a;
        {bus.b_sign, bus.b_exp, bus.b_man} = b;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        if (hold_iv) begin
            r = $urandom;
            {bus.a_sign, bus.a_exp, bus.a_man} = r;
            bus.op_sub = ~sub;
        end else bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        got = {bus.res_sign, bus.res_exp, bus.res_man};
        check({tag, " latency"}, 64'(lat), 64'(el));
        check({tag, " result"}, 64'(got), 64'(er));
        check({tag, " flags"}, {bus.overflow, bus.inexact}, {eo, ei});
        check({tag, " in_ready/busy"}, {bus.in_ready, bus.busy}, 2'b01);
        repeat (stall) begin
            @(posedge clk);
            #1;
            check({tag, " hold"}, {bus.out_valid, bus.in_ready, bus.res_sign, bus.res_exp, bus.res_man,
                                   bus.overflow, bus.inexact}, {1'b1, 1'b0, er, eo, ei});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " release"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    endtask

    initial begin
        logic [31:0] got, ra, rb;
        int          lat, ea, eb;
        bit          seen;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_sub = 1'b0;
        {bus.a_sign, bus.a_exp, bus.a_man} = '0;
        {bus.b_sign, bus.b_exp, bus.b_man} = '0;
        #1;
        check("reset state", {bus.out_valid, bus.busy, bus.in_ready, bus.res_sign, bus.res_exp, bus.res_man,
                              bus.overflow, bus.inexact}, {3'b001, 34'd0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle after reset", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);

        do_op(32'h3F800000, 32'h3F800000, 1'b0, 0, 1'b0, "1+1", got, lat);
        check("1+1 value", 64'(got), 64'h40000000);
        check("1+1 cycles", 64'(lat), 64'd4);
        do_op(32'h3F800000, 32'h3F800000, 1'b1, 0, 1'b0, "1-1", got, lat);
        check("1-1 value", 64'(got), 64'h00000000);
        check("1-1 cycles", 64'(lat), 64'd3);
        do_op(32'h3FC00000, 32'hBF800000, 1'b0, 0, 1'b0, "1.5+-1", got, lat);
        check("1.5+-1 value", 64'(got), 64'h3F000000);
        check("1.5+-1 cycles", 64'(lat), 64'd5);
        do_op(32'h3F800000, 32'h30800000, 1'b0, 0, 1'b0, "flush", got, lat);
        check("flush value", 64'(got), 64'h3F800000);
        check("flush inexact", 64'(bus.inexact), 64'd1);
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0, 1'b0, "max+max", got, lat);
        check("max+max value", 64'(got), 64'h7F800000);
        do_op(32'h40400000, 32'h3F800000, 1'b1, 10, 1'b1, "stall", got, lat);
        check("stall value", 64'(got), 64'h40000000);

        // abort mid-alignment: d=10 keeps the FSM in ALIGN for eleven cycles
        {bus.a_sign, bus.a_exp, bus.a_man} = 32'h3F800000;
        {bus.b_sign, bus.b_exp, bus.b_man} = 32'h3A800000;
        bus.op_sub = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy in align", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async abort", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen = seen | bus.out_valid | bus.busy;
        end
        check("no output after abort", 64'(seen), 64'd0);
        do_op(32'h3F800000, 32'h3A800000, 1'b0, 0, 1'b0, "post-abort", got, lat);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            ea = int'($urandom_range(0, 254));
            eb = (i % 3 == 0) ? ea : (i % 3 == 1) ? ea + int'($urandom_range(0, 60)) - 30 : int'($urandom_range(0, 254));
            eb = (eb < 0) ? 0 : (eb > 254) ? 254 : eb;
            ra[30:23] = 8'(ea);
            rb[30:23] = 8'(eb);
            do_op(ra, rb, 1'($urandom_range(0, 1)), (i % 5 == 0) ? 3 : 0, i % 4 == 1, $sformatf("rnd%0d", i), got, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
